// File: rtl/noc_mem_responder_if.sv
// Bus bundle for noc_mem_responder: request from the packet collector, RAM port-2 access and
// response to the splitter.
//   slave  : responder view (takes requests, drives RAM, produces responses)
//   master : environment view (collector + RAM + splitter)
interface noc_mem_responder_if #(
  parameter int unsigned NODE_COUNT      = 9,
  parameter int unsigned PACKET_ID_WIDTH = 5,
  parameter int unsigned AWIDTH          = 32,
  parameter int unsigned DWIDTH          = 32,
  parameter int unsigned SIZE            = 512,
  parameter int unsigned BYTE            = 8
);
  localparam int unsigned NW = $clog2(NODE_COUNT);
  localparam int unsigned RW = $clog2(SIZE * BYTE / 4);

  // Request from the collector
  logic                       req_valid;
  logic                       req_ready;
  logic [NW-1:0]              req_src;
  logic [PACKET_ID_WIDTH-1:0] req_pkt_id;
  logic                       req_cmd;
  logic [1:0]                 req_width;
  logic [AWIDTH-1:0]          req_addr;
  logic [DWIDTH-1:0]          req_wdata;

  // RAM port 2
  logic                       ram_en;
  logic                       ram_we;
  logic [RW-1:0]              ram_addr;
  logic [3:0]                 ram_be;
  logic [31:0]                ram_wdata;
  logic [31:0]                ram_rdata;

  // Response to the splitter
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [NW-1:0]              rsp_dest;
  logic [PACKET_ID_WIDTH-1:0] rsp_pkt_id;
  logic [1:0]                 rsp_status;
  logic [31:0]                rsp_rdata;

  modport slave (
    input  req_valid, req_src, req_pkt_id, req_cmd, req_width, req_addr, req_wdata,
    output req_ready,
    output ram_en, ram_we, ram_addr, ram_be, ram_wdata,
    input  ram_rdata,
    output rsp_valid, rsp_dest, rsp_pkt_id, rsp_status, rsp_rdata,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_src, req_pkt_id, req_cmd, req_width, req_addr, req_wdata,
    input  req_ready,
    input  ram_en, ram_we, ram_addr, ram_be, ram_wdata,
    output ram_rdata,
    input  rsp_valid, rsp_dest, rsp_pkt_id, rsp_status, rsp_rdata,
    output rsp_ready
  );
endinterface

// File: rtl/noc_mem_responder.sv
// Serves one remote memory request at a time: captures a request packet, checks it against this
// node's memory window, performs the access on RAM port 2 and returns one response packet.
// Ports:
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : noc_mem_responder_if.slave (request in, RAM port 2, response out)
module noc_mem_responder #(
  parameter int unsigned NODE_ID         = 0,
  parameter int unsigned NODE_COUNT      = 9,
  parameter int unsigned PACKET_ID_WIDTH = 5,
  parameter int unsigned AWIDTH          = 32,
  parameter int unsigned DWIDTH          = 32,
  parameter int unsigned SIZE            = 512,
  parameter int unsigned BYTE            = 8
) (
  input logic               clk,
  input logic               rst,
  noc_mem_responder_if.slave bus
);
  localparam int unsigned NW = $clog2(NODE_COUNT);
  localparam int unsigned RW = $clog2(SIZE * BYTE / 4);

  localparam logic [AWIDTH-1:0] WinBase = AWIDTH'(NODE_ID * SIZE * BYTE);
  localparam logic [AWIDTH-1:0] WinSpan = AWIDTH'(SIZE * BYTE - 1);

  localparam logic [1:0] StatusOk  = 2'b01;
  localparam logic [1:0] StatusErr = 2'b10;

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  state_e                     state_q;
  logic [NW-1:0]              src_q;
  logic [PACKET_ID_WIDTH-1:0] pkt_id_q;
  logic                       cmd_q;
  logic [1:0]                 width_q;
  logic [AWIDTH-1:0]          addr_q;
  logic [DWIDTH-1:0]          wdata_q;

  logic                       rsp_valid_q;
  logic [NW-1:0]              rsp_dest_q;
  logic [PACKET_ID_WIDTH-1:0] rsp_pkt_id_q;
  logic [1:0]                 rsp_status_q;
  logic [31:0]                rsp_rdata_q;

  logic [AWIDTH-1:0] offset;
  logic              in_window;
  logic              acc_err;
  logic [1:0]        lane;
  logic [3:0]        be;

  // Address below the base wraps to a huge offset, so one unsigned compare covers both bounds.
  always_comb begin
    offset    = addr_q - WinBase;
    in_window = (offset <= WinSpan);
    lane      = addr_q[1:0];
    acc_err   = !in_window
              || (width_q == 2'b11)
              || ((width_q == 2'b01) && addr_q[0])
              || ((width_q == 2'b10) && (addr_q[1:0] != 2'b00));
    unique case (width_q)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      default: be = 4'b1111;
    endcase
  end

  // RAM strobe is only raised in ACCESS for a legal request; rst blocks a coincident strobe.
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_be    = '0;
    bus.ram_wdata = '0;
    if ((state_q == StAccess) && !rst && !acc_err) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = cmd_q;
      bus.ram_addr  = offset[RW+1:2];
      bus.ram_be    = be;
      bus.ram_wdata = 32'(wdata_q) << {lane, 3'b000};
    end
  end

  assign bus.req_ready  = (state_q == StIdle) && !rst;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_dest   = rsp_dest_q;
  assign bus.rsp_pkt_id = rsp_pkt_id_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.rsp_rdata  = rsp_rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      src_q        <= '0;
      pkt_id_q     <= '0;
      cmd_q        <= 1'b0;
      width_q      <= 2'b00;
      addr_q       <= '0;
      wdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dest_q   <= '0;
      rsp_pkt_id_q <= '0;
      rsp_status_q <= 2'b00;
      rsp_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            src_q    <= bus.req_src;
            pkt_id_q <= bus.req_pkt_id;
            cmd_q    <= bus.req_cmd;
            width_q  <= bus.req_width;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            state_q  <= StAccess;
          end
        end
        StAccess: begin
          rsp_dest_q   <= src_q;
          rsp_pkt_id_q <= pkt_id_q;
          if (acc_err) begin
            rsp_status_q <= StatusErr;
            rsp_rdata_q  <= '0;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end else if (cmd_q) begin
            rsp_status_q <= StatusOk;
            rsp_rdata_q  <= '0;
            rsp_valid_q  <= 1'b1;
            state_q      <= StResp;
          end else begin
            state_q <= StWait;
          end
        end
        StWait: begin
          // RAM has one cycle of read latency, so data issued in ACCESS is present here.
          rsp_rdata_q  <= bus.ram_rdata;
          rsp_status_q <= StatusOk;
          rsp_valid_q  <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_noc_mem_responder.sv
// Randomised and directed bench for noc_mem_responder (NODE_ID = 1, window 0x1000-0x1FFF).
// A byte-addressed associative array stands in for the node memory as the reference.
module tb_noc_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  noc_mem_responder_if #(
    .NODE_COUNT(9), .PACKET_ID_WIDTH(5), .AWIDTH(32), .DWIDTH(32), .SIZE(512), .BYTE(8)
  ) bus ();

  noc_mem_responder #(
    .NODE_ID(1), .NODE_COUNT(9), .PACKET_ID_WIDTH(5), .AWIDTH(32), .DWIDTH(32), .SIZE(512),
    .BYTE(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // RAM port-2 model, 1-cycle read latency
  logic [31:0] ram_mem [0:1023];
  initial begin
    for (int i = 0; i < 1024; i++) ram_mem[i] = 32'h0;
    bus.ram_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we) begin
        for (int l = 0; l < 4; l++)
          if (bus.ram_be[l]) ram_mem[bus.ram_addr][8*l +: 8] <= bus.ram_wdata[8*l +: 8];
      end else begin
        bus.ram_rdata <= ram_mem[bus.ram_addr];
      end
    end
  end

  // Reference model
  bit [7:0] ref_mem [bit [31:0]];

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit exp_err(input logic [1:0] w, input logic [31:0] a);
    if (a < 32'h1000 || a > 32'h1FFF) return 1'b1;
    if (w == 2'd3) return 1'b1;
    if (a % nbytes(w) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    logic [31:0] base;
    w = 32'h0;
    base = a - (a % 4);
    for (int i = 0; i < 4; i++)
      if (ref_mem.exists(base + i)) w[8*i +: 8] = ref_mem[base + i];
    return w;
  endfunction

  function automatic logic [3:0] exp_be(input logic [1:0] w, input logic [31:0] a);
    logic [3:0] be;
    int off;
    be = 4'h0;
    off = int'(a % 4);
    for (int i = 0; i < nbytes(w); i++) be[off + i] = 1'b1;
    return be;
  endfunction

  function automatic logic [9:0] exp_ram_addr(input logic [31:0] a);
    return 10'((a - 32'h1000) / 4);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [31:0] a);
    return d << (8 * (a % 4));
  endfunction

  // Observations of the last transaction driven by run_txn
  int          o_lat, o_en_lat, o_en_cnt;
  logic        o_we;
  logic [9:0]  o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wdata;
  logic [3:0]  o_dest;
  logic [4:0]  o_id;
  logic [1:0]  o_status;
  logic [31:0] o_rdata;

  // Drives one request and records what the DUT does; latency counts cycles after handshake edge.
  task automatic run_txn(input logic cmd, input logic [1:0] width, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] src, input logic [4:0] id,
                         input bit hold);
    int k;
    o_lat = -1; o_en_lat = -1; o_en_cnt = 0; o_we = 1'b0; o_addr = '0; o_be = '0;
    o_wdata = '0; o_dest = '0; o_id = '0; o_status = '0; o_rdata = '0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_cmd = cmd; bus.req_width = width; bus.req_addr = addr;
    bus.req_wdata = wdata; bus.req_src = src; bus.req_pkt_id = id;
    k = 0;
    while (!bus.req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.ram_en) begin
        o_en_cnt++;
        if (o_en_lat < 0) begin
          o_en_lat = c; o_we = bus.ram_we; o_addr = bus.ram_addr; o_be = bus.ram_be;
          o_wdata = bus.ram_wdata;
        end
      end
      if (bus.rsp_valid) begin
        o_lat = c; o_dest = bus.rsp_dest; o_id = bus.rsp_pkt_id; o_status = bus.rsp_status;
        o_rdata = bus.rsp_rdata;
        break;
      end
    end
    if (o_lat > 0 && !hold) @(posedge clk);
    if (cmd && !exp_err(width, addr))
      for (int i = 0; i < nbytes(width); i++) ref_mem[addr + i] = wdata[8*i +: 8];
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1; bus.req_cmd = 1'b0; bus.req_width = 2'd0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_src = '0; bus.req_pkt_id = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_dest, bus.rsp_pkt_id, bus.rsp_status, bus.rsp_rdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_rsp: got v=%b d=%0d id=%0d st=%b rd=%h want all 0", bus.rsp_valid,
               bus.rsp_dest, bus.rsp_pkt_id, bus.rsp_status, bus.rsp_rdata);
    end
    tests_run++;
    if ({bus.ram_en, bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ram: got en=%b we=%b be=%b a=%h wd=%h want all 0", bus.ram_en,
               bus.ram_we, bus.ram_be, bus.ram_addr, bus.ram_wdata);
    end
    tests_run++;
    if (bus.req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_low: got %b want 0", bus.req_ready);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_high: got %b want 1", bus.req_ready);
    end
  endtask

  task automatic test_word_write_read;
    run_txn(1'b1, 2'd2, 32'h1004, 32'hDEADBEEF, 4'd3, 5'd7, 1'b0);
    tests_run++;
    if ({o_en_lat, o_we, o_addr, o_be, o_wdata} !== {32'sd1, 1'b1, 10'd1, 4'b1111, 32'hDEADBEEF})
    begin
      tests_failed++;
      $display("FAIL ww_ram: got lat=%0d we=%b a=%0d be=%b wd=%h want 1 1 1 1111 deadbeef",
               o_en_lat, o_we, o_addr, o_be, o_wdata);
    end
    tests_run++;
    if ({o_lat, o_dest, o_id, o_status, o_rdata} !== {32'sd2, 4'd3, 5'd7, 2'b01, 32'h0}) begin
      tests_failed++;
      $display("FAIL ww_rsp: got lat=%0d d=%0d id=%0d st=%b rd=%h want 2 3 7 01 0", o_lat, o_dest,
               o_id, o_status, o_rdata);
    end
    run_txn(1'b0, 2'd2, 32'h1004, 32'h0, 4'd3, 5'd8, 1'b0);
    tests_run++;
    if ({o_lat, o_status, o_rdata, o_we} !== {32'sd3, 2'b01, ref_word(32'h1004), 1'b0}) begin
      tests_failed++;
      $display("FAIL wr_read: got lat=%0d st=%b rd=%h we=%b want 3 01 %h 0", o_lat, o_status,
               o_rdata, o_we, ref_word(32'h1004));
    end
  endtask

  task automatic test_subword;
    run_txn(1'b1, 2'd0, 32'h1007, 32'h000000AA, 4'd1, 5'd1, 1'b0);
    tests_run++;
    if ({o_be, o_wdata} !== {4'b1000, 32'hAA000000}) begin
      tests_failed++;
      $display("FAIL byte_wr: got be=%b wd=%h want 1000 aa000000", o_be, o_wdata);
    end
    run_txn(1'b1, 2'd1, 32'h1002, 32'h00001234, 4'd2, 5'd2, 1'b0);
    tests_run++;
    if ({o_be, o_wdata, o_lat} !== {4'b1100, 32'h12340000, 32'sd2}) begin
      tests_failed++;
      $display("FAIL half_wr: got be=%b wd=%h lat=%0d want 1100 12340000 2", o_be, o_wdata, o_lat);
    end
    run_txn(1'b0, 2'd0, 32'h1007, 32'h0, 4'd2, 5'd3, 1'b0);
    tests_run++;
    if (o_rdata !== ref_word(32'h1004)) begin
      tests_failed++;
      $display("FAIL byte_rd: got %h want %h", o_rdata, ref_word(32'h1004));
    end
    run_txn(1'b0, 2'd1, 32'h1002, 32'h0, 4'd2, 5'd4, 1'b0);
    tests_run++;
    if (o_rdata !== ref_word(32'h1000)) begin
      tests_failed++;
      $display("FAIL half_rd: got %h want %h", o_rdata, ref_word(32'h1000));
    end
  endtask

  task automatic test_errors;
    logic [31:0] e_addr [4] = '{32'h2000, 32'h0FFC, 32'h1001, 32'h1000};
    logic [1:0]  e_wid  [4] = '{2'd2, 2'd2, 2'd1, 2'd3};
    logic        e_cmd  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_txn(e_cmd[i], e_wid[i], e_addr[i], 32'hFFFFFFFF, 4'd4, 5'(i), 1'b0);
      tests_run++;
      if ({o_lat, o_status, o_rdata, o_en_cnt} !== {32'sd2, 2'b10, 32'h0, 32'sd0}) begin
        tests_failed++;
        $display("FAIL err_%0d: got lat=%0d st=%b rd=%h en=%0d want 2 10 0 0", i, o_lat,
                 o_status, o_rdata, o_en_cnt);
      end
    end
    // LIMIT is inclusive
    run_txn(1'b0, 2'd0, 32'h1FFF, 32'h0, 4'd0, 5'd9, 1'b0);
    tests_run++;
    if ({o_lat, o_status, o_addr, o_be} !== {32'sd3, 2'b01, exp_ram_addr(32'h1FFF), 4'b1000})
    begin
      tests_failed++;
      $display("FAIL limit_rd: got lat=%0d st=%b a=%0d be=%b want 3 01 1023 1000", o_lat,
               o_status, o_addr, o_be);
    end
  endtask

  task automatic test_back_to_back;
    int seen;
    logic [31:0] d;
    d = $urandom;
    seen = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_cmd = 1'b1; bus.req_width = 2'd2; bus.req_addr = 32'h1010;
    bus.req_wdata = d; bus.req_src = 4'd1; bus.req_pkt_id = 5'd1; bus.rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (bus.req_ready) seen++;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[32'h1010 + i] = d[8*i +: 8];
    tests_run++;
    if (seen !== 4) begin
      tests_failed++;
      $display("FAIL b2b_accepts: got %0d want 4 in 12 cycles", seen);
    end
  endtask

  task automatic test_backpressure;
    bus.rsp_ready = 1'b0;
    run_txn(1'b1, 2'd2, 32'h1020, 32'h0BADF00D, 4'd5, 5'd9, 1'b1);
    tests_run++;
    if (o_lat !== 2) begin
      tests_failed++;
      $display("FAIL bp_first_lat: got %0d want 2", o_lat);
    end
    bus.req_valid = 1'b1; bus.req_cmd = 1'b0; bus.req_width = 2'd2; bus.req_addr = 32'h1020;
    bus.req_src = 4'd6; bus.req_pkt_id = 5'd10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.rsp_valid, bus.rsp_dest, bus.rsp_pkt_id, bus.rsp_status, bus.rsp_rdata, bus.req_ready}
          !== {1'b1, 4'd5, 5'd9, 2'b01, 32'h0, 1'b0}) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: got v=%b d=%0d id=%0d st=%b rd=%h rdy=%b want 1 5 9 01 0 0",
                 c, bus.rsp_valid, bus.rsp_dest, bus.rsp_pkt_id, bus.rsp_status, bus.rsp_rdata,
                 bus.req_ready);
      end
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL bp_release: got rdy=%b v=%b want 1 0", bus.req_ready, bus.rsp_valid);
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus.ram_en, bus.ram_we} !== 2'b10) begin
      tests_failed++;
      $display("FAIL bp_second_access: got en=%b we=%b want 1 0", bus.ram_en, bus.ram_we);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_dest, bus.rsp_pkt_id, bus.rsp_rdata}
        !== {1'b1, 4'd6, 5'd10, ref_word(32'h1020)}) begin
      tests_failed++;
      $display("FAIL bp_second_rsp: got v=%b d=%0d id=%0d rd=%h want 1 6 10 %h", bus.rsp_valid,
               bus.rsp_dest, bus.rsp_pkt_id, bus.rsp_rdata, ref_word(32'h1020));
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_cmd = 1'b0; bus.req_width = 2'd2; bus.req_addr = 32'h1004;
    bus.req_src = 4'd2; bus.req_pkt_id = 5'd2;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.rsp_valid, bus.ram_en, bus.req_ready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rstmid_abort: got v=%b en=%b rdy=%b want 0 0 0", bus.rsp_valid, bus.ram_en,
               bus.req_ready);
    end
    rst = 1'b0;
    #1;
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_ready: got %b want 1", bus.req_ready);
    end
    // Write whose ACCESS cycle coincides with rst must not reach the RAM
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_cmd = 1'b1; bus.req_width = 2'd2; bus.req_addr = 32'h1008;
    bus.req_wdata = 32'h55AA55AA;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.ram_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_gate: got en=%b want 0", bus.ram_en);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_txn(1'b1, 2'd2, 32'h100C, 32'hCAFEF00D, 4'd2, 5'd3, 1'b0);
    tests_run++;
    if ({o_lat, o_en_lat, o_status} !== {32'sd2, 32'sd1, 2'b01}) begin
      tests_failed++;
      $display("FAIL rstmid_fresh: got lat=%0d en_lat=%0d st=%b want 2 1 01", o_lat, o_en_lat,
               o_status);
    end
    run_txn(1'b0, 2'd2, 32'h1008, 32'h0, 4'd2, 5'd4, 1'b0);
    tests_run++;
    if (o_rdata !== ref_word(32'h1008)) begin
      tests_failed++;
      $display("FAIL rstmid_nowrite: got %h want %h", o_rdata, ref_word(32'h1008));
    end
  endtask

  task automatic test_random;
    logic        cmd;
    logic [1:0]  wid;
    logic [31:0] addr, d, exp_rd;
    logic [3:0]  src;
    logic [4:0]  id;
    bit          err;
    int          sel, exp_lat;
    for (int n = 0; n < 60; n++) begin
      cmd = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      wid = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      addr = 32'h0FF0 + $urandom_range(0, 15);
      else if (sel == 1) addr = 32'h2000 + $urandom_range(0, 15);
      else               addr = 32'h1000 + $urandom_range(0, 32'hFFF);
      if (sel > 4 && wid != 2'd3) addr = addr - (addr % nbytes(wid));
      d = $urandom;
      src = 4'($urandom_range(0, 8));
      id = 5'($urandom_range(0, 31));
      err = exp_err(wid, addr);
      exp_rd = (err || cmd) ? 32'h0 : ref_word(addr);
      exp_lat = (err || cmd) ? 2 : 3;
      run_txn(cmd, wid, addr, d, src, id, 1'b0);
      tests_run++;
      if ({o_lat, o_dest, o_id, o_status, o_rdata, o_en_cnt}
          !== {exp_lat, src, id, err ? 2'b10 : 2'b01, exp_rd, err ? 32'sd0 : 32'sd1}) begin
        tests_failed++;
        $display("FAIL rnd_rsp_%0d: cmd=%b w=%0d a=%h got lat=%0d d=%0d id=%0d st=%b rd=%h en=%0d",
                 n, cmd, wid, addr, o_lat, o_dest, o_id, o_status, o_rdata, o_en_cnt);
      end
      if (!err) begin
        tests_run++;
        if ({o_we, o_addr, o_be} !== {cmd, exp_ram_addr(addr), exp_be(wid, addr)}) begin
          tests_failed++;
          $display("FAIL rnd_ram_%0d: a=%h got we=%b ra=%0d be=%b want %b %0d %b", n, addr, o_we,
                   o_addr, o_be, cmd, exp_ram_addr(addr), exp_be(wid, addr));
        end
        if (cmd) begin
          tests_run++;
          if (o_wdata !== exp_wdata(d, addr)) begin
            tests_failed++;
            $display("FAIL rnd_wdata_%0d: got %h want %h", n, o_wdata, exp_wdata(d, addr));
          end
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_write_read();
    test_subword();
    test_errors();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
